// File: rtl/expr_seq_pkg.sv
// Shared types, operand-bundle layout and a bundle packing helper for expr_eval_sequencer.
package expr_seq_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int OPW_DEF  = 60;
  localparam int RESW_DEF = 90;

  // Field widths, identical for the A and B halves
  localparam int W0 = 4;
  localparam int W1 = 5;
  localparam int W2 = 6;
  localparam int W3 = 4;
  localparam int W4 = 5;
  localparam int W5 = 6;
  localparam int HALFW = W0 + W1 + W2 + W3 + W4 + W5;

  // Bit offsets (LSB) within the bundle; a0 occupies the MSBs
  localparam int OFF_B5 = 0;
  localparam int OFF_B4 = OFF_B5 + W5;
  localparam int OFF_B3 = OFF_B4 + W4;
  localparam int OFF_B2 = OFF_B3 + W3;
  localparam int OFF_B1 = OFF_B2 + W2;
  localparam int OFF_B0 = OFF_B1 + W1;
  localparam int OFF_A5 = OFF_B0 + W0;
  localparam int OFF_A4 = OFF_A5 + W5;
  localparam int OFF_A3 = OFF_A4 + W4;
  localparam int OFF_A2 = OFF_A3 + W3;
  localparam int OFF_A1 = OFF_A2 + W2;
  localparam int OFF_A0 = OFF_A1 + W1;

  function automatic logic [OPW_DEF-1:0] pack_ops(
    input logic [W0-1:0] a0, input logic [W1-1:0] a1, input logic [W2-1:0] a2,
    input logic [W3-1:0] a3, input logic [W4-1:0] a4, input logic [W5-1:0] a5,
    input logic [W0-1:0] b0, input logic [W1-1:0] b1, input logic [W2-1:0] b2,
    input logic [W3-1:0] b3, input logic [W4-1:0] b4, input logic [W5-1:0] b5
  );
    return {a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5};
  endfunction

endpackage

// File: rtl/expr_seq_rr_arb.sv
// Combinational rotating-priority arbiter: the winner is the first request after 'last'.
module expr_seq_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(NREQ);

  int unsigned idx;

  // Scan from the farthest candidate back to last+1 so the nearest one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/expr_eval_sequencer.sv
// Round-robin sequencer sharing one fixed-latency expression datapath between NREQ requesters.
// Optional EXPR_SEQ_CHECKSUM_EN adds res_checksum, a rotate/XOR signature of accepted responses.
module expr_eval_sequencer
  import expr_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF,
  parameter int LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OPW-1:0]     req_ops,
  output logic [OPW-1:0]          dp_ops,
  input  logic [RESW-1:0]         dp_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RESW-1:0]         rsp_data,
`ifdef EXPR_SEQ_CHECKSUM_EN
  output logic [RESW-1:0]         res_checksum,
`endif
  output logic                    busy,
  output logic [15:0]             issue_count
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 3;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  expr_seq_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (|req_valid) state_nxt = WAIT;
      end
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_ops      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      issue_count <= '0;
      cnt         <= '0;
      last_grant  <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          dp_ops      <= req_ops[gnt_idx*OPW +: OPW];
          rsp_id      <= gnt_idx;
          last_grant  <= gnt_idx;
          issue_count <= issue_count + 16'd1;
          cnt         <= CW'(LAT - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= dp_res;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef EXPR_SEQ_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) res_checksum <= '0;
    else if (rsp_valid && rsp_ready)
      res_checksum <= {res_checksum[RESW-2:0], res_checksum[RESW-1]} ^ rsp_data;
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_expr_eval_sequencer.sv
// Scoreboard bench for expr_eval_sequencer with a combinational {30'b0, dp_ops} datapath stub.
// Also checks res_checksum when built with EXPR_SEQ_CHECKSUM_EN.
module tb_expr_eval_sequencer;
  import expr_seq_pkg::*;

  localparam int NREQ = 4;
  localparam int OPW  = 60;
  localparam int RESW = 90;
  localparam int LAT  = 1;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_ops;
  logic [OPW-1:0]      dp_ops;
  logic [RESW-1:0]     dp_res;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [RESW-1:0]     rsp_data;
  logic                busy;
  logic [15:0]         issue_count;
`ifdef EXPR_SEQ_CHECKSUM_EN
  logic [RESW-1:0]     res_checksum;
  logic [RESW-1:0]     cks_m = '0;
`endif

  always #5 clk = ~clk;

  assign dp_res = {{(RESW-OPW){1'b0}}, dp_ops};

  expr_eval_sequencer #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ops     (req_ops),
    .dp_ops      (dp_ops),
    .dp_res      (dp_res),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
`ifdef EXPR_SEQ_CHECKSUM_EN
    .res_checksum(res_checksum),
`endif
    .busy        (busy),
    .issue_count (issue_count)
  );

  typedef struct {
    logic [IW-1:0]   id;
    logic [RESW-1:0] data;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding op at a time, rotating priority, response LAT+1 cycles after the grant decision.
  bit              outstanding = 0;
  int unsigned     rdy_cyc = 0;
  int              last_m = NREQ - 1;
  logic [15:0]     cnt_m = '0;
  logic [OPW-1:0]  dp_exp = '0;
  int              win;
  int              cand;
  logic [NREQ-1:0] exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      last_m      = NREQ - 1;
      cnt_m       = '0;
      dp_exp      = '0;
      q.delete();
    end else begin
      chk("busy", RESW'(busy), RESW'(outstanding));
      chk("rsp_valid", RESW'(rsp_valid), RESW'(outstanding && cyc >= rdy_cyc));
      chk("issue_count", RESW'(issue_count), RESW'(cnt_m));
      chk("dp_ops", RESW'(dp_ops), RESW'(dp_exp));
      if (outstanding) begin
        chk("req_ready_busy", RESW'(req_ready), '0);
        if (cyc >= rdy_cyc && rsp_ready) outstanding = 0;
      end else begin
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
          cand = (last_m + k) % NREQ;
          if (win < 0 && req_valid[cand]) win = cand;
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", RESW'(req_ready), RESW'(exp_rdy));
        if (win >= 0) begin
          dp_exp = req_ops[win*OPW +: OPW];
          q.push_back('{id: IW'(win), data: {{(RESW-OPW){1'b0}}, dp_exp}});
          last_m = win;
          cnt_m  = cnt_m + 16'd1;
          outstanding = 1;
          rdy_cyc = cyc + 1 + LAT;
        end
      end
    end
  end

  // Monitor: whenever a response is presented it must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
`ifdef EXPR_SEQ_CHECKSUM_EN
      cks_m = '0;
`endif
    end else begin
`ifdef EXPR_SEQ_CHECKSUM_EN
      chk("res_checksum", res_checksum, cks_m);
`endif
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
        end else begin
          chk("rsp_id", RESW'(rsp_id), RESW'(q[0].id));
          chk("rsp_data", rsp_data, q[0].data);
          if (rsp_ready) begin
`ifdef EXPR_SEQ_CHECKSUM_EN
            cks_m = {cks_m[RESW-2:0], cks_m[RESW-1]} ^ q[0].data;
`endif
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      req_ops[i*OPW +: OPW] = pack_ops(
        W0'($urandom), W1'($urandom), W2'($urandom), W3'($urandom), W4'($urandom), W5'($urandom),
        W0'($urandom), W1'($urandom), W2'($urandom), W3'($urandom), W4'($urandom), W5'($urandom));
  endtask

  bit found;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_ops   = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single request from requester 0
    req_ops[0 +: OPW] = 60'h0123456789ABCDE;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (6) step();

    // All four requesting continuously
    req_valid = 4'hF;
    for (int n = 0; n < 20; n++) begin
      rand_ops();
      step();
    end

    // Backpressure held in RESP, ops changing after grant
    rsp_ready = 1'b0;
    for (int n = 0; n < 12; n++) begin
      rand_ops();
      step();
    end
    rsp_ready = 1'b1;
    repeat (6) step();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(9) < 7);
      step();
    end

    // Reset while an op is in WAIT, then requesters 0 and 3 contend
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (busy && !rsp_valid) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reach_wait: got no WAIT cycle expected one within 20 cycles");
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1001;
    rand_ops();
    step();
    req_valid = '0;
    repeat (6) step();

    // Drain
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("drain_queue_empty", RESW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
